// File: rtl/jtcps1_bank_sched_pkg.sv
// Shared state encodings and bank indices for the CPS1 SDRAM bank scheduler.
package jtcps1_bank_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RFSH = 2'd3
  } sched_state_t;

  localparam logic [1:0] BA_RAM = 2'd0;  // main CPU RAM / VRAM
  localparam logic [1:0] BA_SND = 2'd1;  // sound / PCM
  localparam logic [1:0] BA_GFX = 2'd2;  // graphics
  localparam logic [1:0] BA_ROM = 2'd3;  // 68k ROM

  // Round-robin starts at last+1, so parking the pointer on bank 3 serves bank 0 first
  localparam logic [1:0] LAST_RST = BA_ROM;

  // Only bank 0 may write; write bits of the other banks never raise a request
  function automatic logic [3:0] bank_req(input logic [3:0] rd, input logic wr0);
    bank_req = rd | {3'b000, wr0};
  endfunction

endpackage

// File: rtl/jtcps1_bank_sched_if.sv
// Bank request bus (requesters -> scheduler) and SDRAM command port (scheduler -> controller).
interface jtcps1_bank_if #(
  parameter int AW = 22
);
  logic [4*AW-1:0] ba_addr;
  logic [3:0]      ba_rd;
  logic [3:0]      ba_wr;
  logic [15:0]     ba0_din;
  logic [1:0]      ba0_din_m;
  logic [3:0]      ba_ack;
  logic [3:0]      ba_rdy;

  modport master (
    output ba_addr, ba_rd, ba_wr, ba0_din, ba0_din_m,
    input  ba_ack, ba_rdy
  );

  modport slave (
    input  ba_addr, ba_rd, ba_wr, ba0_din, ba0_din_m,
    output ba_ack, ba_rdy
  );
endinterface

interface jtcps1_sdram_if #(
  parameter int AW = 22
);
  logic [AW-1:0] sdram_addr;
  logic [1:0]    sdram_ba;
  logic          sdram_rd;
  logic          sdram_wr;
  logic          sdram_rfsh;
  logic [15:0]   sdram_din;
  logic [1:0]    sdram_din_m;
  logic          ctrl_ack;
  logic          ctrl_rdy;

  modport master (
    output sdram_addr, sdram_ba, sdram_rd, sdram_wr, sdram_rfsh, sdram_din, sdram_din_m,
    input  ctrl_ack, ctrl_rdy
  );

  modport slave (
    input  sdram_addr, sdram_ba, sdram_rd, sdram_wr, sdram_rfsh, sdram_din, sdram_din_m,
    output ctrl_ack, ctrl_rdy
  );
endinterface

// File: rtl/jtcps1_bank_sched_rr_pick.sv
// Combinational 4-way round-robin picker: first requesting bank after 'last', wrapping.
module jtcps1_rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] idx,
  output logic       valid
);

  // Scan from farthest to nearest so the nearest requester after 'last' wins
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (req[last + 2'(k)]) begin
        idx   = last + 2'(k);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtcps1_bank_sched.sv
// CPS1 SDRAM bank scheduler: four request channels onto one command port, with idle-time refresh.
// Optional JTCPS1_BA0_PRIO_EN: bank 0 beats banks 1..3 and refresh; the rest stay round-robin.
module jtcps1_bank_sched
  import jtcps1_bank_sched_pkg::*;
#(
  parameter int AW          = 22,
  parameter int RFSH_PERIOD = 384
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           refresh_en,
  jtcps1_bank_if.slave   bus,
  jtcps1_sdram_if.master sdram
);

  localparam int            CW       = (RFSH_PERIOD > 1) ? $clog2(RFSH_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RFSH_PERIOD - 1);

  sched_state_t  state, state_nxt;
  logic [1:0]    last, gnt;
  logic [CW-1:0] rfsh_cnt;
  logic          rfsh_pend, rfsh_wrap;
  logic [3:0]    req, req_pick;
  logic [1:0]    rr_idx, pick_idx;
  logic          rr_vld, pick_vld, pick_we;
  logic          cmd_rd, cmd_wr, cmd_rfsh;
  logic          rd_nxt, wr_nxt, rfsh_nxt, txn_done;
  logic [3:0]    ack_q, rdy_q, ack_nxt, rdy_nxt;
  logic [AW-1:0] addr_q, addr_sel;
  logic [15:0]   din_q;
  logic [1:0]    din_m_q;
  logic          unused_ok;

  assign unused_ok = &{1'b0, bus.ba_wr[3:1]};
  assign req       = bank_req(bus.ba_rd, bus.ba_wr[0]);

`ifdef JTCPS1_BA0_PRIO_EN
  assign req_pick = {req[3:1], 1'b0};
  assign pick_idx = req[BA_RAM] ? BA_RAM : rr_idx;
  assign pick_vld = req[BA_RAM] | rr_vld;
`else
  assign req_pick = req;
  assign pick_idx = rr_idx;
  assign pick_vld = rr_vld;
`endif

  jtcps1_rr_pick u_pick (
    .req   (req_pick),
    .last  (last),
    .idx   (rr_idx),
    .valid (rr_vld)
  );

  // Read wins over write when bank 0 raises both
  assign pick_we = (pick_idx == BA_RAM) & bus.ba_wr[0] & ~bus.ba_rd[0];

  always_comb begin
    addr_sel = '0;
    for (int n = 0; n < 4; n++) begin
      if (pick_idx == 2'(n)) addr_sel = bus.ba_addr[n*AW +: AW];
    end
  end

  // State and control-output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      last     <= LAST_RST;
      cmd_rd   <= 1'b0;
      cmd_wr   <= 1'b0;
      cmd_rfsh <= 1'b0;
      ack_q    <= '0;
      rdy_q    <= '0;
    end else begin
      state    <= state_nxt;
      cmd_rd   <= rd_nxt;
      cmd_wr   <= wr_nxt;
      cmd_rfsh <= rfsh_nxt;
      ack_q    <= ack_nxt;
      rdy_q    <= rdy_nxt;
      if (txn_done) last <= gnt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pick_vld)       state_nxt = ST_CMD;
        else if (rfsh_pend) state_nxt = ST_RFSH;
      end
      ST_CMD: begin
        if (sdram.ctrl_ack) state_nxt = sdram.ctrl_rdy ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (sdram.ctrl_rdy) state_nxt = ST_IDLE;
      end
      ST_RFSH: begin
        if (sdram.ctrl_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_nxt   = cmd_rd;
    wr_nxt   = cmd_wr;
    rfsh_nxt = cmd_rfsh;
    ack_nxt  = '0;
    rdy_nxt  = '0;
    txn_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          rd_nxt = ~pick_we;
          wr_nxt = pick_we;
        end else if (rfsh_pend) begin
          rfsh_nxt = 1'b1;
        end
      end
      ST_CMD: begin
        if (sdram.ctrl_ack) begin
          rd_nxt       = 1'b0;
          wr_nxt       = 1'b0;
          ack_nxt[gnt] = 1'b1;
          if (sdram.ctrl_rdy) begin
            rdy_nxt[gnt] = 1'b1;
            txn_done     = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (sdram.ctrl_rdy) begin
          rdy_nxt[gnt] = 1'b1;
          txn_done     = 1'b1;
        end
      end
      ST_RFSH: begin
        if (sdram.ctrl_ack) rfsh_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // Request latch: captured on the grant decision, stable for the whole transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      din_m_q <= '0;
    end else if (state == ST_IDLE && pick_vld) begin
      gnt     <= pick_idx;
      addr_q  <= addr_sel;
      din_q   <= bus.ba0_din;
      din_m_q <= bus.ba0_din_m;
    end
  end

  // Refresh timer: a wrap landing on the same edge as the refresh ack keeps pending set
  assign rfsh_wrap = refresh_en && (rfsh_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rfsh_cnt  <= '0;
      rfsh_pend <= 1'b0;
    end else begin
      if (!refresh_en || rfsh_wrap) rfsh_cnt <= '0;
      else                          rfsh_cnt <= rfsh_cnt + 1'b1;
      if (rfsh_wrap)                                rfsh_pend <= 1'b1;
      else if (state == ST_RFSH && sdram.ctrl_ack)  rfsh_pend <= 1'b0;
    end
  end

  assign sdram.sdram_addr  = addr_q;
  assign sdram.sdram_ba    = gnt;
  assign sdram.sdram_rd    = cmd_rd;
  assign sdram.sdram_wr    = cmd_wr;
  assign sdram.sdram_rfsh  = cmd_rfsh;
  assign sdram.sdram_din   = din_q;
  assign sdram.sdram_din_m = din_m_q;
  assign bus.ba_ack        = ack_q;
  assign bus.ba_rdy        = rdy_q;

endmodule

// File: tb/tb_jtcps1_bank_sched.sv
// Self-checking bench for jtcps1_bank_sched: directed scenarios plus randomized traffic vs a transaction model.
module tb_jtcps1_bank_sched;

  localparam int AW = 22;
  localparam int RP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          refresh_en = 1'b0;
  logic [3:0]    ba_rd = '0;
  logic [3:0]    ba_wr = '0;
  logic [AW-1:0] a [4];
  logic [15:0]   din = '0;
  logic [1:0]    dm = '0;
  logic          ctrl_ack = 1'b0;
  logic          ctrl_rdy = 1'b0;

  jtcps1_bank_if  #(.AW(AW)) bif ();
  jtcps1_sdram_if #(.AW(AW)) sif ();

  assign bif.ba_addr   = {a[3], a[2], a[1], a[0]};
  assign bif.ba_rd     = ba_rd;
  assign bif.ba_wr     = ba_wr;
  assign bif.ba0_din   = din;
  assign bif.ba0_din_m = dm;
  assign sif.ctrl_ack  = ctrl_ack;
  assign sif.ctrl_rdy  = ctrl_rdy;

  jtcps1_bank_sched #(.AW(AW), .RFSH_PERIOD(RP)) dut (
    .clk        (clk),
    .rst        (rst),
    .refresh_en (refresh_en),
    .bus        (bif),
    .sdram      (sif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: what the command port and pulse outputs must show after each edge
  logic          m_rd, m_wr, m_rf, m_wait, m_pend;
  logic [3:0]    m_ack, m_rdy;
  logic [1:0]    m_ba, m_last;
  logic [AW-1:0] m_addr;
  logic [15:0]   m_din;
  logic [1:0]    m_dm;
  int            m_cnt;

  function automatic int pick(input logic [3:0] req, input logic [1:0] last);
`ifdef JTCPS1_BA0_PRIO_EN
    if (req[0]) return 0;
    for (int k = 1; k <= 4; k++) begin
      int b = (int'(last) + k) % 4;
      if (b != 0 && req[b]) return b;
    end
`else
    for (int k = 1; k <= 4; k++) begin
      int b = (int'(last) + k) % 4;
      if (req[b]) return b;
    end
`endif
    return -1;
  endfunction

  task automatic model_edge();
    logic [3:0] req;
    int g;
    bit wrap, clr;
    m_ack = '0;
    m_rdy = '0;
    if (rst) begin
      {m_rd, m_wr, m_rf, m_wait, m_pend} = '0;
      m_ba = '0; m_addr = '0; m_din = '0; m_dm = '0;
      m_last = 2'd3; m_cnt = 0;
      return;
    end
    wrap = refresh_en && (m_cnt == RP - 1);
    clr  = 1'b0;
    if (m_rd || m_wr) begin
      if (ctrl_ack) begin
        m_ack[m_ba] = 1'b1;
        m_rd = 1'b0; m_wr = 1'b0;
        if (ctrl_rdy) begin m_rdy[m_ba] = 1'b1; m_last = m_ba; end
        else m_wait = 1'b1;
      end
    end else if (m_wait) begin
      if (ctrl_rdy) begin m_rdy[m_ba] = 1'b1; m_last = m_ba; m_wait = 1'b0; end
    end else if (m_rf) begin
      if (ctrl_ack) begin m_rf = 1'b0; clr = 1'b1; end
    end else begin
      req = ba_rd | {3'b000, ba_wr[0]};
      g = pick(req, m_last);
      if (g >= 0) begin
        m_ba = 2'(g); m_addr = a[g]; m_din = din; m_dm = dm;
        m_wr = (g == 0) && ba_wr[0] && !ba_rd[0];
        m_rd = !m_wr;
      end else if (m_pend) begin
        m_rf = 1'b1;
      end
    end
    m_pend = (m_pend && !clr) || wrap;
    m_cnt  = (!refresh_en || wrap) ? 0 : m_cnt + 1;
  endtask

  bit          hold_reqs = 1'b0;
  bit          prev_cmd = 1'b0;
  int          grants[$];
  logic [AW-1:0] gaddr[$];
  int          ack_cnt[4];
  int          rdy_cnt[4];

  task automatic clear_stats();
    grants.delete();
    gaddr.delete();
    for (int n = 0; n < 4; n++) begin ack_cnt[n] = 0; rdy_cnt[n] = 0; end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("cmd", 64'({sif.sdram_rd, sif.sdram_wr, sif.sdram_rfsh}), 64'({m_rd, m_wr, m_rf}));
    chk("ack", 64'(bif.ba_ack), 64'(m_ack));
    chk("rdy", 64'(bif.ba_rdy), 64'(m_rdy));
    chk("ba", 64'(sif.sdram_ba), 64'(m_ba));
    chk("addr", 64'(sif.sdram_addr), 64'(m_addr));
    chk("din", 64'({sif.sdram_din, sif.sdram_din_m}), 64'({m_din, m_dm}));
    chk("excl", 64'(($countones({sif.sdram_rd, sif.sdram_wr, sif.sdram_rfsh}) <= 1) &&
                    ($countones(bif.ba_ack) <= 1) && ($countones(bif.ba_rdy) <= 1)), 64'd1);
    if ((sif.sdram_rd || sif.sdram_wr) && !prev_cmd) begin
      grants.push_back(int'(sif.sdram_ba));
      gaddr.push_back(sif.sdram_addr);
    end
    prev_cmd = sif.sdram_rd || sif.sdram_wr;
    for (int n = 0; n < 4; n++) begin
      ack_cnt[n] += int'(bif.ba_ack[n]);
      rdy_cnt[n] += int'(bif.ba_rdy[n]);
      if (!hold_reqs && bif.ba_ack[n]) begin
        ba_rd[n] = 1'b0;
        if (n == 0) ba_wr[0] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic drain();
    ba_rd = '0; ba_wr = '0;
    ctrl_ack = 1'b1; ctrl_rdy = 1'b1;
    repeat (6) cyc();
    ctrl_ack = 1'b0; ctrl_rdy = 1'b0;
  endtask

  initial begin
    int n;
    int exp_order[5];
    for (int i = 0; i < 4; i++) a[i] = '0;

    // Reset state
    do_reset();
    chk("rst_out", 64'({sif.sdram_rd, sif.sdram_wr, sif.sdram_rfsh, bif.ba_ack, bif.ba_rdy,
                        sif.sdram_ba, sif.sdram_addr}), 64'd0);

    // Single read on bank 3
    clear_stats();
    a[3] = 22'h1234;
    ba_rd = 4'b1000;
    for (int i = 1; i <= 10; i++) begin
      ctrl_ack = (i == 3);
      ctrl_rdy = (i == 6);
      cyc();
    end
    ctrl_ack = 1'b0; ctrl_rdy = 1'b0;
    chk("s1_grants", 64'(grants.size()), 64'd1);
    if (grants.size() > 0) begin
      chk("s1_ba", 64'(grants[0]), 64'd3);
      chk("s1_addr", 64'(gaddr[0]), 64'h1234);
    end
    chk("s1_ack3", 64'(ack_cnt[3]), 64'd1);
    chk("s1_rdy3", 64'(rdy_cnt[3]), 64'd1);

    // All four banks held, controller answers at once
    do_reset();
    clear_stats();
    hold_reqs = 1'b1;
    ba_rd = 4'hF;
    ctrl_ack = 1'b1; ctrl_rdy = 1'b1;
    for (int i = 0; i < 30 && grants.size() < 5; i++) cyc();
    hold_reqs = 1'b0;
`ifdef JTCPS1_BA0_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    chk("rr_count", 64'(grants.size() >= 5), 64'd1);
    for (int i = 0; i < 5; i++)
      if (i < grants.size()) chk($sformatf("rr_order%0d", i), 64'(grants[i]), 64'(exp_order[i]));
    drain();

    // Bank 0 write, then an ignored write request on bank 2
    din = 16'hBEEF; dm = 2'b10;
    ba_wr = 4'b0001;
    cyc();
    chk("wr_cmd", 64'({sif.sdram_rd, sif.sdram_wr}), 64'b01);
    chk("wr_din", 64'(sif.sdram_din), 64'hBEEF);
    chk("wr_mask", 64'(sif.sdram_din_m), 64'b10);
    ctrl_ack = 1'b1; cyc();
    ctrl_ack = 1'b0; ctrl_rdy = 1'b1; cyc();
    ctrl_rdy = 1'b0;
    ba_wr = 4'b0100;
    n = 0;
    repeat (6) begin cyc(); n += int'(sif.sdram_rd || sif.sdram_wr); end
    chk("wr2_nogrant", 64'(n), 64'd0);
    ba_wr = '0;

    // Refresh after counter wrap, held until acknowledged
    do_reset();
    refresh_en = 1'b1;
    n = 0;
    for (int i = 0; i < 30 && !sif.sdram_rfsh; i++) begin cyc(); n++; end
    chk("rfsh_lat", 64'(n), 64'(RP + 1));
    repeat (3) begin cyc(); chk("rfsh_hold", 64'(sif.sdram_rfsh), 64'd1); end
    ctrl_ack = 1'b1; cyc();
    ctrl_ack = 1'b0;
    chk("rfsh_drop", 64'(sif.sdram_rfsh), 64'd0);
    refresh_en = 1'b0;
    cyc();

    // Reset while waiting for data
    clear_stats();
    ba_rd = 4'b0100;
    cyc();
    ctrl_ack = 1'b1; cyc();
    ctrl_ack = 1'b0; rst = 1'b1; cyc();
    rst = 1'b0; ctrl_rdy = 1'b1; cyc();
    ctrl_rdy = 1'b0;
    repeat (3) cyc();
    chk("rst_wait_rdy", 64'(rdy_cnt[2]), 64'd0);
    ba_rd = 4'b0011;
    cyc();
    chk("rst_next_gnt", 64'({sif.sdram_rd, sif.sdram_ba}), 64'({1'b1, 2'd0}));
    drain();

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (!ba_rd[b] && !(b == 0 && ba_wr[0])) begin
          a[b] = AW'($urandom);
          if ($urandom_range(0, 3) == 0) begin
            if (b == 0) begin
              case ($urandom_range(0, 2))
                0:       begin ba_rd[0] = 1'b1; ba_wr[0] = 1'b0; end
                1:       begin ba_rd[0] = 1'b0; ba_wr[0] = 1'b1; end
                default: begin ba_rd[0] = 1'b1; ba_wr[0] = 1'b1; end
              endcase
            end else begin
              ba_rd[b] = 1'b1;
            end
          end
        end else if ($urandom_range(0, 40) == 0) begin
          ba_rd[b] = 1'b0;
          if (b == 0) ba_wr[0] = 1'b0;
        end
      end
      ba_wr[3:1] = 3'($urandom);
      din = 16'($urandom);
      dm = 2'($urandom);
      ctrl_ack = ($urandom_range(0, 2) == 0);
      ctrl_rdy = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) refresh_en = ~refresh_en;
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
